// File: rtl/alu_issue.sv
// alu_issue: ID/EX issue register feeding the execute-stage ALU.
// Resolves operands through EX/MEM/WB bypass and stalls on load-use.
module alu_issue (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_pc,
   input  logic [4:0]  in_aluop,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic        in_use_rs1,
   input  logic        in_use_rs2,
   input  logic [63:0] in_rs1_data,
   input  logic [63:0] in_rs2_data,
   input  logic [63:0] in_imm,
   input  logic        in_a_pc,
   input  logic        in_b_imm,
   input  logic [4:0]  in_rd,
   input  logic        in_wen,
   input  logic        ex_wen,
   input  logic [4:0]  ex_rd,
   input  logic [63:0] ex_data,
   input  logic        ex_is_load,
   input  logic        mem_wen,
   input  logic [4:0]  mem_rd,
   input  logic [63:0] mem_data,
   input  logic        mem_pending,
   input  logic        wb_wen,
   input  logic [4:0]  wb_rd,
   input  logic [63:0] wb_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] alu_a,
   output logic [63:0] alu_b,
   output logic [4:0]  alu_op,
   output logic [63:0] out_pc,
   output logic [4:0]  out_rd,
   output logic        out_wen,
   output logic [63:0] out_rs2_val
);

   logic        r_valid;
   logic [63:0] r_a;
   logic [63:0] r_b;
   logic [4:0]  r_op;
   logic [63:0] r_pc;
   logic [4:0]  r_rd;
   logic        r_wen;
   logic [63:0] r_rs2;

   logic        w_ex1, w_mem1, w_wb1;
   logic        w_ex2, w_mem2, w_wb2;
   logic [63:0] w_rs1_val;
   logic [63:0] w_rs2_val;
   logic        w_haz1, w_haz2;
   logic        w_hazard;
   logic        w_accept;

   assign w_ex1  = ex_wen  && (ex_rd  == in_rs1);
   assign w_mem1 = mem_wen && (mem_rd == in_rs1);
   assign w_wb1  = wb_wen  && (wb_rd  == in_rs1);
   assign w_ex2  = ex_wen  && (ex_rd  == in_rs2);
   assign w_mem2 = mem_wen && (mem_rd == in_rs2);
   assign w_wb2  = wb_wen  && (wb_rd  == in_rs2);

   // rs1 bypass select: x0 reads zero, youngest producer wins
   always_comb begin
      w_rs1_val = in_rs1_data;
      if (in_use_rs1) begin
         if (in_rs1 == 5'd0) w_rs1_val = 64'd0;
         else if (w_ex1)     w_rs1_val = ex_data;
         else if (w_mem1)    w_rs1_val = mem_data;
         else if (w_wb1)     w_rs1_val = wb_data;
      end
   end

   // rs2 bypass select, same priority as rs1
   always_comb begin
      w_rs2_val = in_rs2_data;
      if (in_use_rs2) begin
         if (in_rs2 == 5'd0) w_rs2_val = 64'd0;
         else if (w_ex2)     w_rs2_val = ex_data;
         else if (w_mem2)    w_rs2_val = mem_data;
         else if (w_wb2)     w_rs2_val = wb_data;
      end
   end

   // a non-load EX match supplies the value and masks a pending MEM
   assign w_haz1 = in_use_rs1 && (in_rs1 != 5'd0) &&
                   (w_ex1 ? ex_is_load : (w_mem1 && mem_pending));
   assign w_haz2 = in_use_rs2 && (in_rs2 != 5'd0) &&
                   (w_ex2 ? ex_is_load : (w_mem2 && mem_pending));
   assign w_hazard = in_valid && (w_haz1 || w_haz2);

   assign in_ready = !flush && !w_hazard && (!r_valid || out_ready);
   assign w_accept = in_valid && in_ready;

   // output register: reset > flush > accept > drain
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= '0;
         r_pc    <= '0;
         r_rd    <= '0;
         r_wen   <= 1'b0;
         r_rs2   <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_a     <= in_a_pc ? in_pc : w_rs1_val;
         r_b     <= in_b_imm ? in_imm : w_rs2_val;
         r_op    <= in_aluop;
         r_pc    <= in_pc;
         r_rd    <= in_rd;
         r_wen   <= in_wen;
         r_rs2   <= w_rs2_val;
      end else if (r_valid && out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid   = r_valid;
   assign alu_a       = r_a;
   assign alu_b       = r_b;
   assign alu_op      = r_op;
   assign out_pc      = r_pc;
   assign out_rd      = r_rd;
   assign out_wen     = r_wen;
   assign out_rs2_val = r_rs2;

endmodule
